// File: rtl/dram_arbiter.sv
// dram_arbiter: two-requester arbiter in front of a single-port DRAM.
// Each accepted request runs IDLE -> ISSUE -> RESP. A request with an
// out-of-range address skips ISSUE and answers with an error.
// Optional build macro DRAM_ARB_ROUND_ROBIN_EN: alternates the winner under
// contention. Without it, requester 0 always wins.
module dram_arbiter #(
  parameter int ADDR_MIN = 8,
  parameter int ADDR_MAX = 6144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [15:0] resp0_rdata,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [15:0] resp1_rdata,
  output logic        resp1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_d_in,
  input  logic [15:0] mem_d_out
);

  localparam logic [15:0] ADDR_LO = 16'(ADDR_MIN);
  localparam logic [15:0] ADDR_HI = 16'(ADDR_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state;
  state_t      state_next;

  logic        grant_id;
  logic        grant_any;
  logic        handshake;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_in_range;

  logic        lat_id;
  logic        lat_we;
  logic        lat_err;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] lat_rdata;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  logic        last_grant;

  // Pick the winner: under contention the requester not granted last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end
  end

  // Remember who was granted on every handshake; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (handshake) begin
      last_grant <= grant_id;
    end
  end
`else
  // Pick the winner: requester 0 always wins when it is asking.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = ~req0_valid;
  end
`endif

  // Select the winning request fields, range-check, and drive ready in IDLE.
  always_comb begin
    sel_we       = grant_id ? req1_we    : req0_we;
    sel_addr     = grant_id ? req1_addr  : req0_addr;
    sel_wdata    = grant_id ? req1_wdata : req0_wdata;
    sel_in_range = (sel_addr >= ADDR_LO) && (sel_addr <= ADDR_HI);
    req0_ready   = (state == IDLE) && !rst && grant_any && !grant_id;
    req1_ready   = (state == IDLE) && !rst && grant_any && grant_id;
    handshake    = req0_ready | req1_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: bad addresses bypass the DRAM and go straight to RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = sel_in_range ? ISSUE : RESP;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the request at handshake and capture read data at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rdata <= '0;
    end else if (handshake) begin
      lat_id    <= grant_id;
      lat_we    <= sel_we;
      lat_err   <= ~sel_in_range;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_rdata <= '0;
    end else if (state == ISSUE) begin
      lat_rdata <= lat_we ? 16'h0000 : mem_d_out;
    end
  end

  // Outputs decoded from state: DRAM strobes in ISSUE, response strobe in RESP.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_d_in    = '0;
    resp0_valid = 1'b0;
    resp0_rdata = '0;
    resp0_err   = 1'b0;
    resp1_valid = 1'b0;
    resp1_rdata = '0;
    resp1_err   = 1'b0;
    case (state)
      ISSUE: begin
        mem_read  = ~lat_we;
        mem_write = lat_we;
        mem_addr  = lat_addr;
        mem_d_in  = lat_wdata;
      end
      RESP: begin
        if (lat_id) begin
          resp1_valid = 1'b1;
          resp1_rdata = lat_rdata;
          resp1_err   = lat_err;
        end else begin
          resp0_valid = 1'b1;
          resp0_rdata = lat_rdata;
          resp0_err   = lat_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small DRAM model that writes on negedge.
module tb_dram_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_we, req0_ready;
  logic [15:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_we, req1_ready;
  logic [15:0] req1_addr, req1_wdata;
  logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [15:0] resp0_rdata, resp1_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_d_in, mem_d_out;

  logic [15:0] dram [0:65535];

  int checks;
  int failures;

  dram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_d_in(mem_d_in), .mem_d_out(mem_d_out)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DRAM model: combinational read, write on the falling edge.
  assign mem_d_out = dram[mem_addr];
  always @(negedge clk) begin
    if (mem_write) dram[mem_addr] <= mem_d_in;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [15:0] a0,
                               input logic [15:0] d0, input logic v1, input logic we1,
                               input logic [15:0] a1, input logic [15:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      $error("[TB] %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // One complete access from a single requester, checked cycle by cycle.
  task automatic doAccess(input string tag, input logic port, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic expErr, input logic [15:0] expRdata);
    applyStimulus(!port, we, addr, wdata, port, we, addr, wdata);
    checkFlag({tag, "/ready"}, port ? req1_ready : req0_ready, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    if (!expErr) begin
      checkFlag({tag, "/mem_read"}, mem_read, !we);
      checkFlag({tag, "/mem_write"}, mem_write, we);
      checkOutput({tag, "/mem_addr"}, mem_addr, addr);
      if (we) checkOutput({tag, "/mem_d_in"}, mem_d_in, wdata);
      cycle();
    end
    checkFlag({tag, "/resp_valid"}, port ? resp1_valid : resp0_valid, 1'b1);
    checkFlag({tag, "/other_valid"}, port ? resp0_valid : resp1_valid, 1'b0);
    checkOutput({tag, "/rdata"}, port ? resp1_rdata : resp0_rdata, expRdata);
    checkFlag({tag, "/err"}, port ? resp1_err : resp0_err, expErr);
    checkFlag({tag, "/resp_strobe"}, mem_read | mem_write, 1'b0);
    cycle();
    checkFlag({tag, "/resp_done"}, resp0_valid | resp1_valid, 1'b0);
  endtask

  logic [3:0] expGrants;

  initial begin
    for (int i = 0; i < 65536; i++) dram[i] = 16'h0000;
    dram[16'h0010] = 16'hBEEF;
    checks   = 0;
    failures = 0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    expGrants = 4'b1010;
`else
    expGrants = 4'b0000;
`endif

    // Ready must stay low while reset is held, even with requests pending.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0);
    checkFlag("rst/ready0", req0_ready, 1'b0);
    checkFlag("rst/ready1", req1_ready, 1'b0);
    cycle();
    cycle();
    checkFlag("rst/mem_read", mem_read, 1'b0);
    checkFlag("rst/mem_write", mem_write, 1'b0);
    checkOutput("rst/mem_addr", mem_addr, 16'h0000);
    checkFlag("rst/resp0", resp0_valid, 1'b0);
    checkFlag("rst/resp1", resp1_valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    cycle();
    $display("[TB] reset checks done");

    // Basic read of preloaded data.
    doAccess("rd_beef", 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 16'hBEEF);

    // A request withdrawn before the edge leaves the arbiter idle.
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    checkFlag("withdraw/mem_read", mem_read, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkFlag("withdraw/still_idle", req0_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Write then read back on requester 1; pending read is held off in ISSUE/RESP.
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0100, 16'h1234);
    checkFlag("wr1/ready", req1_ready, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0);
    checkFlag("wr1/mem_write", mem_write, 1'b1);
    checkOutput("wr1/mem_d_in", mem_d_in, 16'h1234);
    checkFlag("wr1/no_accept_issue", req1_ready, 1'b0);
    cycle();
    checkFlag("wr1/resp", resp1_valid, 1'b1);
    checkOutput("wr1/rdata", resp1_rdata, 16'h0000);
    checkFlag("wr1/no_accept_resp", req1_ready, 1'b0);
    cycle();
    checkFlag("rd1/ready", req1_ready, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkFlag("rd1/mem_read", mem_read, 1'b1);
    cycle();
    checkFlag("rd1/resp", resp1_valid, 1'b1);
    checkOutput("rd1/rdata", resp1_rdata, 16'h1234);
    checkFlag("rd1/err", resp1_err, 1'b0);
    cycle();

    // Address range edges.
    doAccess("err_0004", 1'b0, 1'b0, 16'h0004, 16'h0, 1'b1, 16'h0000);
    doAccess("err_2000", 1'b0, 1'b0, 16'h2000, 16'h0, 1'b1, 16'h0000);
    doAccess("err_0007", 1'b0, 1'b0, 16'h0007, 16'h0, 1'b1, 16'h0000);
    doAccess("err_1801", 1'b1, 1'b1, 16'h1801, 16'hFFFF, 1'b1, 16'h0000);
    doAccess("ok_1800", 1'b1, 1'b1, 16'h1800, 16'hA5A5, 1'b0, 16'h0000);
    doAccess("ok_0008", 1'b0, 1'b0, 16'h0008, 16'h0, 1'b0, 16'h0000);
    doAccess("rd_1800", 1'b0, 1'b0, 16'h1800, 16'h0, 1'b0, 16'hA5A5);

    // Contention from a fresh reset: both requesters valid for four accesses.
    resetDut();
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0100, 16'h0);
    for (int i = 0; i < 4; i++) begin
      checkFlag($sformatf("arb%0d/ready0", i), req0_ready, !expGrants[i]);
      checkFlag($sformatf("arb%0d/ready1", i), req1_ready, expGrants[i]);
      cycle();
      cycle();
      checkFlag($sformatf("arb%0d/resp0", i), resp0_valid, !expGrants[i]);
      checkFlag($sformatf("arb%0d/resp1", i), resp1_valid, expGrants[i]);
      checkOutput($sformatf("arb%0d/rdata", i), resp0_rdata | resp1_rdata,
                  expGrants[i] ? 16'h1234 : 16'hBEEF);
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset in the middle of a write: the write lands, the response is dropped.
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h5555);
    checkFlag("abort/ready", req1_ready, 1'b1);
    cycle();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    checkFlag("abort/mem_write", mem_write, 1'b1);
    checkOutput("abort/mem_addr", mem_addr, 16'h0200);
    cycle();
    checkFlag("abort/no_resp", resp1_valid, 1'b0);
    checkFlag("abort/strobe_off", mem_write, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
    checkFlag("abort/ready_in_rst", req1_ready, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    checkFlag("abort/idle_resp", resp1_valid, 1'b0);
    doAccess("abort_rd", 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 16'h5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
